ivl_uvm_sync_fifo: RTL and testbench

Single-clock linear FIFO that serves as the design under test for the fifo_index checker flow. It buffers WIDTH-bit words up to DEPTH entries. It exports qualified push/pop strobes (push_ok, pop_ok) that connect directly to the checker's push/pop inputs, so the checker observes only legal transfers. It also provides count, full/empty status and sticky overflow/underflow flags for bench scoreboarding.

---
 rtl/ivl_uvm_sync_fifo.sv | 70 +++++++
 tb/tb_ivl_uvm_sync_fifo.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/ivl_uvm_sync_fifo.sv
// Single-clock linear FIFO with qualified push/pop strobes, occupancy
// count, full/empty status and sticky overflow/underflow flags.
// Pointers wrap explicitly at DEPTH-1, so any DEPTH >= 1 is supported.
module ivl_uvm_sync_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count,
  output logic             push_ok,
  output logic             pop_ok,
  output logic             overflow,
  output logic             underflow
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign pop_ok  = pop & ~empty;
  // A push into a full FIFO is legal only when an accepted pop frees a slot.
  assign push_ok = push & (~full | pop_ok);

  // Storage write; contents are deliberately left uncleared by reset.
  always_ff @(posedge clk) begin
    if (reset && push_ok) mem[wr_ptr] <= din;
  end

  // Pointers, occupancy, registered read data and sticky error flags.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      dout      <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= next_ptr(wr_ptr);
      if (pop_ok) begin
        rd_ptr <= next_ptr(rd_ptr);
        dout   <= mem[rd_ptr];
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (push && !push_ok) overflow  <= 1'b1;
      if (pop && empty)     underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ivl_uvm_sync_fifo.sv
// Bench for ivl_uvm_sync_fifo: a DEPTH=4 and a DEPTH=3 instance are driven
// in turn by directed scenarios; a queue-based model is compared against
// every output on every falling edge, and literal checks pin the model.
module tb_ivl_uvm_sync_fifo;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_s  [2];
  logic       push_s [2];
  logic       pop_s  [2];
  logic [7:0] din_s  [2];
  logic [7:0] dout_s [2];
  logic       full_s [2];
  logic       empty_s[2];
  logic       wok_s  [2];
  logic       pok_s  [2];
  logic       ovf_s  [2];
  logic       udf_s  [2];
  logic [2:0] cnt4;
  logic [1:0] cnt3;

  ivl_uvm_sync_fifo #(.WIDTH(8), .DEPTH(4)) dut4 (
    .clk(clk), .reset(rst_s[0]), .push(push_s[0]), .din(din_s[0]),
    .pop(pop_s[0]), .dout(dout_s[0]), .full(full_s[0]), .empty(empty_s[0]),
    .count(cnt4), .push_ok(wok_s[0]), .pop_ok(pok_s[0]),
    .overflow(ovf_s[0]), .underflow(udf_s[0])
  );

  ivl_uvm_sync_fifo #(.WIDTH(8), .DEPTH(3)) dut3 (
    .clk(clk), .reset(rst_s[1]), .push(push_s[1]), .din(din_s[1]),
    .pop(pop_s[1]), .dout(dout_s[1]), .full(full_s[1]), .empty(empty_s[1]),
    .count(cnt3), .push_ok(wok_s[1]), .pop_ok(pok_s[1]),
    .overflow(ovf_s[1]), .underflow(udf_s[1])
  );

  // Behavioural model: a queue of stored words per instance.
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic [7:0] mdout[2];
  bit         movf[2];
  bit         mudf[2];
  bit         armed[2];

  int tests  = 0;
  int failed = 0;

  function automatic int dep(input int d);
    return (d == 0) ? 4 : 3;
  endfunction

  function automatic int msize(input int d);
    return (d == 0) ? q0.size() : q1.size();
  endfunction

  function automatic int cnt(input int d);
    return (d == 0) ? int'(cnt4) : int'(cnt3);
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Apply one rising edge to the model, using the inputs presented to it.
  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      int n;
      bit po, pu;
      if (!rst_s[k]) begin
        if (k == 0) q0.delete(); else q1.delete();
        mdout[k] = 8'h00;
        movf[k]  = 1'b0;
        mudf[k]  = 1'b0;
        armed[k] = 1'b1;
      end else begin
        n  = msize(k);
        po = pop_s[k] && (n > 0);
        pu = push_s[k] && ((n < dep(k)) || po);
        if (po) mdout[k] = (k == 0) ? q0.pop_front() : q1.pop_front();
        if (pu) begin
          if (k == 0) q0.push_back(din_s[k]); else q1.push_back(din_s[k]);
        end
        if (push_s[k] && !pu) movf[k] = 1'b1;
        if (pop_s[k] && (n == 0)) mudf[k] = 1'b1;
      end
    end
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (armed[k]) begin
        automatic int    n  = msize(k);
        automatic int    d  = dep(k);
        automatic int    c  = cnt(k);
        automatic bit    po = pop_s[k] && (n > 0);
        automatic bit    pu = push_s[k] && ((n < d) || po);
        automatic string p  = $sformatf("d%0d_", d);
        chk({p, "count"},     c,                 n);
        chk({p, "full"},      int'(full_s[k]),   int'(n == d));
        chk({p, "empty"},     int'(empty_s[k]),  int'(n == 0));
        chk({p, "pop_ok"},    int'(pok_s[k]),    int'(po));
        chk({p, "push_ok"},   int'(wok_s[k]),    int'(pu));
        chk({p, "dout"},      int'(dout_s[k]),   int'(mdout[k]));
        chk({p, "overflow"},  int'(ovf_s[k]),    int'(movf[k]));
        chk({p, "underflow"}, int'(udf_s[k]),    int'(mudf[k]));
        chk({p, "inv_full_empty"}, int'(full_s[k] & empty_s[k]), 0);
        chk({p, "inv_count_le_depth"}, int'(c <= d), 1);
        chk({p, "inv_push_ok"}, int'(!wok_s[k] || (c < d) || pok_s[k]), 1);
        chk({p, "inv_pop_ok"},  int'(!pok_s[k] || (c > 0)), 1);
      end
    end
  end

  // Drive one cycle on instance d; the other instance idles out of reset.
  task automatic step(input int d, input bit pu, input logic [7:0] di,
                      input bit po, input bit rs);
    for (int k = 0; k < 2; k++) begin
      push_s[k] = 1'b0;
      pop_s[k]  = 1'b0;
      din_s[k]  = 8'h00;
      rst_s[k]  = 1'b1;
    end
    push_s[d] = pu;
    pop_s[d]  = po;
    din_s[d]  = di;
    rst_s[d]  = rs;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic scenario(input int d);
    int D;
    D = dep(d);
    // Reset held with push and pop requested.
    repeat (5) step(d, 1'b1, 8'h99, 1'b1, 1'b0);
    chk("rst_count", cnt(d), 0);
    chk("rst_empty", int'(empty_s[d]), 1);
    chk("rst_dout", int'(dout_s[d]), 0);
    chk("rst_ovf", int'(ovf_s[d]), 0);
    chk("rst_udf", int'(udf_s[d]), 0);
    step(d, 1'b0, 8'h00, 1'b0, 1'b1);
    chk("rel_empty", int'(empty_s[d]), 1);
    // Fill, overflow attempt, drain.
    for (int i = 0; i < D; i++) step(d, 1'b1, 8'(8'hA1 + i), 1'b0, 1'b1);
    chk("fill_full", int'(full_s[d]), 1);
    chk("fill_count", cnt(d), D);
    step(d, 1'b1, 8'hFF, 1'b0, 1'b1);
    chk("ovf_flag", int'(ovf_s[d]), 1);
    chk("ovf_count", cnt(d), D);
    for (int i = 0; i < D; i++) begin
      step(d, 1'b0, 8'h00, 1'b1, 1'b1);
      chk("drain_dout", int'(dout_s[d]), 8'hA1 + i);
    end
    chk("drain_empty", int'(empty_s[d]), 1);
    // Underflow, then push+pop on empty.
    step(d, 1'b0, 8'h00, 1'b1, 1'b1);
    chk("udf_flag", int'(udf_s[d]), 1);
    chk("udf_dout_hold", int'(dout_s[d]), 8'hA0 + D);
    step(d, 1'b1, 8'h55, 1'b1, 1'b1);
    chk("emp_pp_count", cnt(d), 1);
    step(d, 1'b0, 8'h00, 1'b1, 1'b1);
    chk("emp_pp_dout", int'(dout_s[d]), 8'h55);
    // Steady push+pop at count 2, wrapping the pointers.
    step(d, 1'b1, 8'hB0, 1'b0, 1'b1);
    step(d, 1'b1, 8'hB1, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      step(d, 1'b1, 8'(8'hB2 + i), 1'b1, 1'b1);
      chk("wrap_dout", int'(dout_s[d]), 8'hB0 + i);
      chk("wrap_count", cnt(d), 2);
    end
    // Push+pop while full.
    for (int i = 0; i < D - 2; i++) step(d, 1'b1, 8'(8'hC0 + i), 1'b0, 1'b1);
    chk("full2_count", cnt(d), D);
    step(d, 1'b1, 8'h77, 1'b1, 1'b1);
    chk("full_pp_count", cnt(d), D);
    chk("full_pp_dout", int'(dout_s[d]), 8'hBA);
    for (int i = 0; i < D; i++) step(d, 1'b0, 8'h00, 1'b1, 1'b1);
    chk("full_pp_last", int'(dout_s[d]), 8'h77);
    // Mid-operation reset with three entries stored.
    for (int i = 0; i < 3; i++) step(d, 1'b1, 8'(8'hD0 + i), 1'b0, 1'b1);
    chk("mid_count", cnt(d), 3);
    step(d, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("mid_rst_count", cnt(d), 0);
    chk("mid_rst_empty", int'(empty_s[d]), 1);
    chk("mid_rst_dout", int'(dout_s[d]), 0);
    chk("mid_rst_flags", int'({ovf_s[d], udf_s[d]}), 0);
    step(d, 1'b0, 8'h00, 1'b1, 1'b1);
    chk("post_rst_dout", int'(dout_s[d]), 0);
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      rst_s[k]  = 1'b0;
      push_s[k] = 1'b0;
      pop_s[k]  = 1'b0;
      din_s[k]  = 8'h00;
      armed[k]  = 1'b0;
    end
    @(posedge clk);
    model_edge();
    #1;
    scenario(0);
    scenario(1);
    step(0, 1'b0, 8'h00, 1'b0, 1'b1);
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
